seq_pattern_detector: RTL and testbench

- Parametrised serial bit-stream pattern detector; next generation of the team's single-pattern Mealy detector.
- Samples one bit per enabled clock and flags when the last PAT_W bits equal PATTERN.
- Detection mode is selectable: Mealy (combinational, same cycle) or Moore (registered, one cycle later). Overlap policy is selectable.
- Keeps a saturating match counter for lab/status readout.

---
 rtl/seq_det_pkg.sv | 10 +
 rtl/sat_counter.sv | 27 ++
 rtl/seq_pattern_detector.sv | 69 ++++++
 tb/tb_seq_pattern_detector.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package seq_det_pkg;
  localparam int MODE_MEALY = 0;
  localparam int MODE_MOORE = 1;

  // Width of a counter that must hold 0..pat_w inclusive.
  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                  cnt_d = '0;
    else if (inc && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign sat = &cnt_q;
endmodule

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: flags when the last PAT_W enabled bits equal
// PATTERN, with Mealy/Moore output timing and optional overlap.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               MODE    = MODE_MEALY,
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data,
  input  logic             en,
  input  logic             clr,
  output logic             res,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);
  localparam int             FW       = fill_w(PAT_W);
  localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_W);
  localparam logic [FW-1:0]  FILL_ARM = FW'(PAT_W - 1);

  // The oldest history bit is shifted out before it is ever compared,
  // so only PAT_W-1 bits of history need to be stored.
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [PAT_W-1:0] window;
  logic [FW-1:0]    fill_q, fill_d;
  logic             res_q, res_d;
  logic             match_now;

  assign window    = {hist_q, data};
  assign match_now = en && (fill_q >= FILL_ARM) && (window == PATTERN);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    res_d  = match_now;
    if (en) begin
      hist_d = window[PAT_W-2:0];
      if (match_now && (OVERLAP == 0)) fill_d = '0;
      else if (fill_q != FILL_MAX)     fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      res_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      res_q  <= res_d;
    end
  end

  assign res = !rst && ((MODE == MODE_MOORE) ? res_q : match_now);

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (match_now),
    .clr (clr),
    .cnt (match_cnt),
    .sat (cnt_sat)
  );
endmodule

// File: tb/tb_seq_pattern_detector.sv
// Checks several detector configurations side by side against a
// queue-based model of "last four accepted bits equal 1011".
module tb_seq_pattern_detector;
  localparam int NDUT = 5;
  // 0: Mealy/overlap  1: Mealy/no-overlap  2: Moore/overlap
  // 3: Mealy/overlap/2-bit counter  4: Moore/no-overlap
  localparam bit IS_MOORE [NDUT] = '{0, 0, 1, 0, 1};
  localparam bit IS_OV    [NDUT] = '{1, 0, 1, 1, 0};
  localparam int CMAX     [NDUT] = '{255, 255, 255, 3, 255};
  localparam logic [3:0] PAT = 4'b1011;

  logic clk = 1'b0, rst = 1'b1, data = 1'b0, en = 1'b0, clr = 1'b0;
  logic [NDUT-1:0] res, sat;
  logic [7:0] cnt0, cnt1, cnt2, cnt4;
  logic [1:0] cnt3;
  logic [7:0] cnt_a [NDUT];

  always #5 clk = ~clk;

  seq_pattern_detector #(.MODE(0), .OVERLAP(1)) u0 (.clk(clk), .rst(rst), .data(data), .en(en),
    .clr(clr), .res(res[0]), .match_cnt(cnt0), .cnt_sat(sat[0]));
  seq_pattern_detector #(.MODE(0), .OVERLAP(0)) u1 (.clk(clk), .rst(rst), .data(data), .en(en),
    .clr(clr), .res(res[1]), .match_cnt(cnt1), .cnt_sat(sat[1]));
  seq_pattern_detector #(.MODE(1), .OVERLAP(1)) u2 (.clk(clk), .rst(rst), .data(data), .en(en),
    .clr(clr), .res(res[2]), .match_cnt(cnt2), .cnt_sat(sat[2]));
  seq_pattern_detector #(.MODE(0), .OVERLAP(1), .CNT_W(2)) u3 (.clk(clk), .rst(rst), .data(data),
    .en(en), .clr(clr), .res(res[3]), .match_cnt(cnt3), .cnt_sat(sat[3]));
  seq_pattern_detector #(.MODE(1), .OVERLAP(0)) u4 (.clk(clk), .rst(rst), .data(data), .en(en),
    .clr(clr), .res(res[4]), .match_cnt(cnt4), .cnt_sat(sat[4]));

  assign cnt_a[0] = cnt0;
  assign cnt_a[1] = cnt1;
  assign cnt_a[2] = cnt2;
  assign cnt_a[3] = {6'd0, cnt3};
  assign cnt_a[4] = cnt4;

  int n_vec = 0;
  int n_miss = 0;

  // Reference model: accepted bits since the last restart, counts, Moore flag.
  bit q [NDUT][$];
  int cnt_m [NDUT];
  bit resq_m [NDUT];

  function automatic bit model_match(input int i, input bit d);
    int n;
    logic [3:0] w;
    n = q[i].size();
    if (n < 3) return 1'b0;
    w = {q[i][n-3], q[i][n-2], q[i][n-1], d};
    return w == PAT;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    bit m, er;
    for (int i = 0; i < NDUT; i++) begin
      m  = en && !rst && model_match(i, data);
      er = rst ? 1'b0 : (IS_MOORE[i] ? resq_m[i] : m);
      n_vec++;
      assert (res[i] === er) else begin
        n_miss++;
        $error("FAIL res[%0d] @%0t: got %b expected %b", i, $time, res[i], er);
      end
      n_vec++;
      assert (cnt_a[i] === 8'(cnt_m[i])) else begin
        n_miss++;
        $error("FAIL cnt[%0d] @%0t: got %0d expected %0d", i, $time, cnt_a[i], cnt_m[i]);
      end
      n_vec++;
      assert (sat[i] === (cnt_m[i] == CMAX[i])) else begin
        n_miss++;
        $error("FAIL sat[%0d] @%0t: got %b expected %b", i, $time, sat[i], cnt_m[i] == CMAX[i]);
      end
    end
  endtask

  task automatic step(input bit d, input bit e, input bit c);
    bit m [NDUT];
    @(negedge clk);
    data = d; en = e; clr = c;
    #1;
    check_all();
    for (int i = 0; i < NDUT; i++) m[i] = e && model_match(i, d);
    @(posedge clk);
    for (int i = 0; i < NDUT; i++) begin
      resq_m[i] = m[i];
      if (c) cnt_m[i] = 0;
      else if (m[i] && cnt_m[i] < CMAX[i]) cnt_m[i]++;
      if (e) begin
        q[i].push_back(d);
        if (m[i] && !IS_OV[i]) q[i].delete();
        else if (q[i].size() > 3) void'(q[i].pop_front());
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      q[i].delete(); cnt_m[i] = 0; resq_m[i] = 1'b0;
    end
    #1;
    check_all();
    #29;
    rst = 1'b0;
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    logic [15:0] b;
    b = bits;
    for (int k = n - 1; k >= 0; k--) step(b[k], 1'b1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NDUT; i++) begin cnt_m[i] = 0; resq_m[i] = 1'b0; end
    #2;
    check_all();
    do_reset();

    // Overlap vs. restart on 1011011
    feed(16'b1011011, 7);
    #1;
    chk("ov_cnt", cnt0, 8'd2);
    chk("nov_cnt", cnt1, 8'd1);
    feed(16'b1011, 4);
    #1;
    chk("nov_cnt2", cnt1, 8'd2);

    // Moore pulse followed by gated cycles
    do_reset();
    feed(16'b1011, 4);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Reset in the middle of a pattern
    do_reset();
    feed(16'b101, 3);
    do_reset();
    feed(16'b1011, 4);
    #1;
    chk("post_rst_cnt", cnt0, 8'd1);

    // Saturation, then clear colliding with a match
    do_reset();
    feed(16'b1011011011011, 13);
    #1;
    chk("sat_cnt", {6'd0, cnt3}, 8'd3);
    chk("sat_flag", {7'd0, sat[3]}, 8'd1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    #1;
    chk("clr_cnt", {6'd0, cnt3}, 8'd0);
    chk("clr_sat", {7'd0, sat[3]}, 8'd0);

    // Gated bits must not enter history
    do_reset();
    feed(16'b10, 2);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    feed(16'b11, 2);
    #1;
    chk("gate_cnt", cnt0, 8'd1);

    // Random traffic
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end
    step(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
